// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART boot loader that fills BRAM port A and releases the core after a checksum match
module imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [3:0]  wea,
    output logic [31:0] addra,
    output logic [31:0] dia,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]      DEPTH     = 32'(DEPTH_WORDS);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_SYNC, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} ld_state_t;

    // UART receiver state
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_next;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_rx_shift;
    logic             w_cnt_half;
    logic             w_cnt_full;
    logic             w_rx_valid;
    logic             w_rx_ferr;
    logic [7:0]       w_rx_byte;

    // Loader state
    ld_state_t        r_ld_state;
    ld_state_t        w_ld_next;
    logic [1:0]       r_byte_cnt;
    logic [31:0]      r_len;
    logic [31:0]      r_index;
    logic [7:0]       r_sum;
    logic [23:0]      r_word;
    logic [3:0]       r_wea;
    logic [31:0]      r_addra;
    logic [31:0]      r_dia;
    logic [31:0]      w_len_full;
    logic             w_last_word;

    assign w_cnt_half  = (r_rx_cnt == C_HALF);
    assign w_cnt_full  = (r_rx_cnt == C_FULL);
    assign w_rx_byte   = r_rx_shift;
    assign w_len_full  = {w_rx_byte, r_len[31:8]};
    assign w_last_word = ((r_index + 32'd1) == r_len);

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // RX next state; the byte strobe fires while the stop bit is sampled
    always_comb begin
        w_rx_next  = r_rx_state;
        w_rx_valid = 1'b0;
        w_rx_ferr  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_next = RX_START;
                end
            end
            RX_START: begin
                if (w_cnt_half) begin
                    w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_cnt_full && (r_bit_idx == 3'd7)) begin
                    w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_cnt_full) begin
                    w_rx_next  = RX_IDLE;
                    w_rx_valid = r_rx_sync;
                    w_rx_ferr  = !r_rx_sync;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // RX synchronizer, bit timer and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= '0;
            r_bit_idx  <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if ((r_rx_state == RX_IDLE) || ((r_rx_state == RX_START) && w_cnt_half) || w_cnt_full) begin
                r_rx_cnt <= '0;
            end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            if (r_rx_state == RX_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_rx_state == RX_DATA) && w_cnt_full) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_bit_idx  <= r_bit_idx + 3'd1;
            end
        end
    end

    // Loader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_state <= S_SYNC;
        end else begin
            r_ld_state <= w_ld_next;
        end
    end

    // Loader next state; a framing error aborts anything short of a finished load
    always_comb begin
        w_ld_next = r_ld_state;
        case (r_ld_state)
            S_SYNC: begin
                if (w_rx_valid && (w_rx_byte == SYNC_BYTE)) w_ld_next = S_LEN;
            end
            S_LEN: begin
                if (w_rx_valid && (r_byte_cnt == 2'd3)) begin
                    if (w_len_full > DEPTH) begin
                        w_ld_next = S_ERR;
                    end else if (w_len_full == 32'd0) begin
                        w_ld_next = S_CSUM;
                    end else begin
                        w_ld_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_rx_valid && (r_byte_cnt == 2'd3) && w_last_word) w_ld_next = S_CSUM;
            end
            S_CSUM: begin
                if (w_rx_valid) w_ld_next = (w_rx_byte == r_sum) ? S_DONE : S_ERR;
            end
            S_DONE: w_ld_next = S_DONE;
            S_ERR: begin
                if (w_rx_valid && (w_rx_byte == SYNC_BYTE)) w_ld_next = S_LEN;
            end
            default: w_ld_next = S_SYNC;
        endcase
        if (w_rx_ferr && (r_ld_state != S_DONE)) begin
            w_ld_next = S_ERR;
        end
    end

    // Loader datapath: length, word assembly, running sum and the BRAM write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= 2'd0;
            r_len      <= 32'd0;
            r_index    <= 32'd0;
            r_sum      <= 8'h00;
            r_word     <= 24'h0;
            r_wea      <= 4'h0;
            r_addra    <= 32'd0;
            r_dia      <= 32'd0;
        end else begin
            r_wea <= 4'h0;
            if (w_rx_valid) begin
                case (r_ld_state)
                    S_SYNC, S_ERR: begin
                        if (w_rx_byte == SYNC_BYTE) begin
                            r_byte_cnt <= 2'd0;
                            r_index    <= 32'd0;
                            r_sum      <= 8'h00;
                        end
                    end
                    S_LEN: begin
                        r_len      <= w_len_full;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    S_DATA: begin
                        r_word     <= {w_rx_byte, r_word[23:8]};
                        r_sum      <= r_sum + w_rx_byte;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_wea   <= 4'hF;
                            r_addra <= r_index << 2;
                            r_dia   <= {w_rx_byte, r_word};
                            r_index <= r_index + 32'd1;
                        end
                    end
                    default: r_byte_cnt <= r_byte_cnt;
                endcase
            end
        end
    end

    assign wea        = r_wea;
    assign addra      = r_addra;
    assign dia        = r_dia;
    assign busy       = (r_ld_state == S_LEN) || (r_ld_state == S_DATA) || (r_ld_state == S_CSUM);
    assign done       = (r_ld_state == S_DONE);
    assign core_rst_n = (r_ld_state == S_DONE);
    assign err        = (r_ld_state == S_ERR);

endmodule
